// File: rtl/traffic_pkg.sv
// Shared lamp-interface definitions for the intersection controller and its
// sequence monitor: phase/fault encodings and the default dwell times.
package traffic_pkg;

  localparam int RED_MIN_DEF    = 4;
  localparam int GREEN_MIN_DEF  = 4;
  localparam int YEL_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_NOT_ONEHOT   = 3'd1,
    ERR_ILLEGAL      = 3'd2,
    ERR_SHORT        = 3'd3,
    ERR_YEL_OVERRUN  = 3'd4,
    ERR_NOT_RED_IDLE = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RED    = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_FAULT  = 3'd4
  } mon_state_e;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamps_t;

  localparam lamps_t LAMP_R = '{r: 1'b1, y: 1'b0, g: 1'b0};
  localparam lamps_t LAMP_Y = '{r: 1'b0, y: 1'b1, g: 1'b0};
  localparam lamps_t LAMP_G = '{r: 1'b0, y: 1'b0, g: 1'b1};

  function automatic logic is_one_hot(input lamps_t l);
    return (l.r ^ l.y ^ l.g) & ~(l.r & l.y & l.g);
  endfunction

endpackage

// File: rtl/light_sequence_monitor_if.sv
// Lamp bus observed by the monitor plus its status outputs.
interface light_sequence_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             R;
  logic             Y;
  logic             G;
  logic             err_clr;
  logic [1:0]       phase;
  logic [CNT_W-1:0] dwell;
  logic             cycle_done;
  logic             err;
  logic [2:0]       err_code;

  modport master (
    output start, R, Y, G, err_clr,
    input  phase, dwell, cycle_done, err, err_code
  );

  modport slave (
    input  start, R, Y, G, err_clr,
    output phase, dwell, cycle_done, err, err_code
  );
endinterface

// File: rtl/light_sequence_monitor_sat_counter.sv
// Saturating dwell counter: clear to 0, load 1, increment, or hold.
module light_sequence_monitor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (load)                  cnt_d = W'(1);
    else if (inc && (cnt_q != '1))  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/light_sequence_monitor.sv
// Passive observer of the R/Y/G lamp outputs: tracks the phase, checks the
// RED->GREEN->YELLOW->RED order and dwell times, latches the first fault.
module light_sequence_monitor
  import traffic_pkg::*;
#(
  parameter int RED_MIN    = RED_MIN_DEF,
  parameter int GREEN_MIN  = GREEN_MIN_DEF,
  parameter int YEL_CYCLES = YEL_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  light_sequence_monitor_if.slave  bus
);
  localparam logic [CNT_W-1:0] RED_MIN_C   = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YEL_C       = CNT_W'(YEL_CYCLES);

  logic       s_start_q, s_start_d;
  logic       s_start_prev_q, s_start_prev_d;
  lamps_t     s_lamp_q, s_lamp_d;
  logic       smp_vld_q, smp_vld_d;
  mon_state_e state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       cycle_done_q, cycle_done_d;
  logic       err_q, err_d;
  err_code_e  err_code_q, err_code_d;

  logic             cnt_clr, cnt_load, cnt_inc;
  logic [CNT_W-1:0] dwell;
  logic             fault;
  err_code_e        fault_code;

  logic one_hot, r_only, y_only, g_only, start_rise;

  always_comb begin
    s_start_d      = bus.start;
    s_start_prev_d = s_start_q;
    s_lamp_d       = '{r: bus.R, y: bus.Y, g: bus.G};
    smp_vld_d      = 1'b1;
  end

  assign one_hot    = is_one_hot(s_lamp_q);
  assign r_only     = (s_lamp_q == LAMP_R);
  assign y_only     = (s_lamp_q == LAMP_Y);
  assign g_only     = (s_lamp_q == LAMP_G);
  assign start_rise = s_start_q & ~s_start_prev_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cycle_done_d = 1'b0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    fault        = 1'b0;
    fault_code   = ERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        // The sample registers hold reset zeros until the first edge after reset.
        if (smp_vld_q) begin
          if (!s_start_q && !r_only) begin
            fault      = 1'b1;
            fault_code = ERR_NOT_RED_IDLE;
          end else if (start_rise && r_only) begin
            state_d  = ST_RED;
            phase_d  = PH_RED;
            cnt_clr  = 1'b0;
            cnt_load = 1'b1;
          end
        end
      end

      ST_RED, ST_GREEN, ST_YELLOW: begin
        if (!one_hot) begin
          fault      = 1'b1;
          fault_code = ERR_NOT_ONEHOT;
        end else if (!s_start_q) begin
          if (r_only) begin
            state_d = ST_IDLE;
            phase_d = PH_IDLE;
            cnt_clr = 1'b1;
          end else begin
            fault      = 1'b1;
            fault_code = ERR_NOT_RED_IDLE;
          end
        end else if (state_q == ST_RED) begin
          if (r_only) cnt_inc = 1'b1;
          else if (g_only) begin
            if (dwell >= RED_MIN_C) begin
              state_d  = ST_GREEN;
              phase_d  = PH_GREEN;
              cnt_load = 1'b1;
            end else begin
              fault      = 1'b1;
              fault_code = ERR_SHORT;
            end
          end else begin
            fault      = 1'b1;
            fault_code = ERR_ILLEGAL;
          end
        end else if (state_q == ST_GREEN) begin
          if (g_only) cnt_inc = 1'b1;
          else if (y_only) begin
            if (dwell >= GREEN_MIN_C) begin
              state_d  = ST_YELLOW;
              phase_d  = PH_YELLOW;
              cnt_load = 1'b1;
            end else begin
              fault      = 1'b1;
              fault_code = ERR_SHORT;
            end
          end else begin
            fault      = 1'b1;
            fault_code = ERR_ILLEGAL;
          end
        end else begin
          if (y_only) begin
            if (dwell < YEL_C) cnt_inc = 1'b1;
            else begin
              fault      = 1'b1;
              fault_code = ERR_YEL_OVERRUN;
            end
          end else if (r_only) begin
            if (dwell == YEL_C) begin
              state_d      = ST_RED;
              phase_d      = PH_RED;
              cnt_load     = 1'b1;
              cycle_done_d = 1'b1;
            end else begin
              fault      = 1'b1;
              fault_code = ERR_SHORT;
            end
          end else begin
            fault      = 1'b1;
            fault_code = ERR_ILLEGAL;
          end
        end
      end

      ST_FAULT: begin
        if (bus.err_clr) begin
          state_d    = ST_IDLE;
          phase_d    = PH_IDLE;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cnt_clr    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // phase and dwell freeze at the values seen when the fault was detected.
    if (fault) begin
      state_d      = ST_FAULT;
      err_d        = 1'b1;
      err_code_d   = fault_code;
      cycle_done_d = 1'b0;
      cnt_clr      = 1'b0;
      cnt_load     = 1'b0;
      cnt_inc      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_start_q      <= 1'b0;
      s_start_prev_q <= 1'b0;
      s_lamp_q       <= '0;
      smp_vld_q      <= 1'b0;
      state_q        <= ST_IDLE;
      phase_q        <= PH_IDLE;
      cycle_done_q   <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      s_start_q      <= s_start_d;
      s_start_prev_q <= s_start_prev_d;
      s_lamp_q       <= s_lamp_d;
      smp_vld_q      <= smp_vld_d;
      state_q        <= state_d;
      phase_q        <= phase_d;
      cycle_done_q   <= cycle_done_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
    end
  end

  light_sequence_monitor_sat_counter #(.W(CNT_W)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .q       (dwell)
  );

  assign bus.phase      = phase_q;
  assign bus.dwell      = dwell;
  assign bus.cycle_done = cycle_done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_light_sequence_monitor.sv
// Directed lamp sequences for light_sequence_monitor; expected outputs are
// queued per stimulus and checked by an independent negedge monitor.
module tb_light_sequence_monitor;
  localparam logic [2:0] LR  = 3'b100;  // {R,Y,G}
  localparam logic [2:0] LY  = 3'b010;
  localparam logic [2:0] LG  = 3'b001;
  localparam logic [2:0] LRG = 3'b101;
  localparam logic [2:0] LALL = 3'b111;
  localparam logic [2:0] LOFF = 3'b000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  light_sequence_monitor_if #(.CNT_W(8)) bus ();

  light_sequence_monitor #(
    .RED_MIN(4), .GREEN_MIN(4), .YEL_CYCLES(2), .CNT_W(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int scn;
    int idx;
    int ph;
    int dw;
    int cd;
    int er;
    int code;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   scn = 0;
  int   idx = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic clr_pend = 1'b0;
  logic tmo_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: owns both counters.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(bus.phase) != e.ph || int'(bus.dwell) != e.dw ||
          int'(bus.cycle_done) != e.cd || int'(bus.err) != e.er ||
          int'(bus.err_code) != e.code) begin
        n_bad++;
        $display("FAIL scn%0d step%0d: got ph=%0d dw=%0d cd=%0d err=%0d code=%0d, want ph=%0d dw=%0d cd=%0d err=%0d code=%0d",
                 e.scn, e.idx, bus.phase, bus.dwell, bus.cycle_done, bus.err, bus.err_code,
                 e.ph, e.dw, e.cd, e.er, e.code);
      end
    end
    if (tmo_flag) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations still pending, want 0", exp_q.size());
      exp_q.delete();
      tmo_flag = 1'b0;
    end
  end

  task automatic push_exp(input int due, input int ph, input int dw, input int cd,
                          input int er, input int code);
    exp_t e;
    e.due = due; e.scn = scn; e.idx = idx;
    e.ph = ph; e.dw = dw; e.cd = cd; e.er = er; e.code = code;
    exp_q.push_back(e);
    idx++;
  endtask

  // One sample per cycle; its effect is visible two edges later. err_clr is
  // not sampled, so it is driven one cycle late to meet the same edge.
  task automatic step(input int s, input logic [2:0] lamp, input int clr,
                      input int ph, input int dw, input int cd, input int er, input int code);
    @(negedge clk);
    bus.start   = (s != 0);
    {bus.R, bus.Y, bus.G} = lamp;
    bus.err_clr = clr_pend;
    clr_pend    = (clr != 0);
    push_exp(cyc + 2, ph, dw, cd, er, code);
  endtask

  task automatic run(input logic [2:0] lamp, input int ph, input int n, input int cd_first);
    for (int i = 0; i < n; i++)
      step(1, lamp, 0, ph, i + 1, (i == 0) ? cd_first : 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, LR, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_fault();
    step(0, LR, 1, 0, 0, 0, 0, 0);
    step(0, LR, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic legal_loop(input int cd_first);
    run(LR, 1, 4, cd_first);
    run(LG, 2, 4, 0);
    run(LY, 3, 2, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.err_clr = clr_pend;
    clr_pend = 1'b0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      tmo_flag = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.R = 1'b1; bus.Y = 1'b0; bus.G = 1'b0; bus.err_clr = 1'b0;
    scn = 0;
    push_exp(cyc, 0, 0, 0, 0, 0);         // reset state
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Two legal loops, then start drops while RED.
    scn = 1; idx = 0;
    idle(2);
    legal_loop(0);
    legal_loop(1);
    run(LR, 1, 1, 1);
    step(0, LR, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Green after only three red cycles.
    scn = 2; idx = 0;
    run(LR, 1, 3, 0);
    step(1, LG,   0, 1, 3, 0, 1, 3);
    step(1, LY,   0, 1, 3, 0, 1, 3);
    step(1, LALL, 0, 1, 3, 0, 1, 3);
    step(0, LOFF, 0, 1, 3, 0, 1, 3);
    clear_fault();

    // R+G during GREEN, then a second violation.
    scn = 3; idx = 0;
    run(LR, 1, 4, 0);
    run(LG, 2, 2, 0);
    step(1, LRG, 0, 2, 2, 0, 1, 1);
    step(1, LY,  0, 2, 2, 0, 1, 1);
    step(1, LR,  0, 2, 2, 0, 1, 1);
    clear_fault();

    // Yellow held three cycles, clear, resume with a legal loop.
    scn = 4; idx = 0;
    legal_loop(0);
    step(1, LY, 0, 3, 2, 0, 1, 4);
    step(1, LY, 0, 3, 2, 0, 1, 4);
    clear_fault();
    legal_loop(0);
    run(LR, 1, 1, 1);
    step(0, LR, 0, 0, 0, 0, 0, 0);

    // start drops with yellow lit.
    scn = 5; idx = 0;
    run(LR, 1, 4, 0);
    run(LG, 2, 4, 0);
    run(LY, 3, 1, 0);
    step(0, LY, 0, 3, 1, 0, 1, 5);
    clear_fault();
    // Not red while idle.
    step(0, LG, 0, 0, 0, 0, 1, 5);
    clear_fault();

    // Asynchronous reset in the middle of GREEN.
    scn = 6; idx = 0;
    run(LR, 1, 4, 0);
    run(LG, 2, 2, 0);
    drain();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    bus.start = 1'b0; {bus.R, bus.Y, bus.G} = LR;
    push_exp(cyc, 0, 0, 0, 0, 0);          // checked before the next rising edge
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    legal_loop(0);
    run(LR, 1, 1, 1);
    step(0, LR, 0, 0, 0, 0, 0, 0);
    drain();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
